// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator front-end input logic.
//   - Key-code constants for the operator and symbol keys on the 4x4 keypad.
//   - State encoding of the keypad scan/debounce FSM.
//   - Small helpers: counter width sizing, keypad code lookup, lowest active
//     row selection and active-low column drive pattern.
// No ports (package).
// ---------------------------------------------------------------------------
package calc_pkg;

    // Codes produced for the non-digit keys.
    localparam logic [3:0] KEY_ADD  = 4'd10;
    localparam logic [3:0] KEY_SUB  = 4'd11;
    localparam logic [3:0] KEY_MUL  = 4'd12;
    localparam logic [3:0] KEY_DIV  = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    // Keypad FSM states.
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } keyState_e;

    // Width of a counter that must hold values 0 .. maxCount-1.
    // A single-value counter still needs one bit to exist.
    function automatic int cntWidth(input int maxCount);
        return (maxCount > 1) ? $clog2(maxCount) : 1;
    endfunction

    // Code for the key at (row, column) of the keypad.
    function automatic logic [3:0] keyCode(input logic [1:0] rowIdx,
                                           input logic [1:0] colIdx);
        logic [3:0] code;
        code = 4'd0;
        case ({rowIdx, colIdx})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd2;
            4'b00_10: code = 4'd3;
            4'b00_11: code = KEY_ADD;
            4'b01_00: code = 4'd4;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd6;
            4'b01_11: code = KEY_SUB;
            4'b10_00: code = 4'd7;
            4'b10_01: code = 4'd8;
            4'b10_10: code = 4'd9;
            4'b10_11: code = KEY_MUL;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = 4'd0;
            4'b11_10: code = KEY_HASH;
            4'b11_11: code = KEY_DIV;
            default:  code = 4'd0;
        endcase
        return code;
    endfunction

    // Index of the lowest row that reads low (active). Only meaningful when
    // at least one row bit is low; an all-high input maps to row 3.
    function automatic logic [1:0] lowestLowRow(input logic [3:0] rowBits);
        logic [1:0] idx;
        if (!rowBits[0]) begin
            idx = 2'd0;
        end else if (!rowBits[1]) begin
            idx = 2'd1;
        end else if (!rowBits[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    // Active-low one-hot column drive for a column index.
    function automatic logic [3:0] colDrive(input logic [1:0] colIdx);
        return ~(4'b0001 << colIdx);
    endfunction

endpackage

// File: rtl/calc_debounce.sv
// ---------------------------------------------------------------------------
// calc_debounce
// Debouncer for a single asynchronous, active-high push-button.
// The raw input is synchronised with two flops, then compared against the
// accepted level once per slot tick. The level flips only after DEB_CNT
// consecutive ticks disagree with it; any agreeing tick restarts the count.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   tick_i     in   one-cycle slot strobe shared with the keypad scanner
//   raw_i      in   raw asynchronous button input
//   level_o    out  debounced (accepted) button level
//   riseReq_o  out  high in the cycle whose clock edge turns level_o 0->1
// ---------------------------------------------------------------------------
module calc_debounce
    import calc_pkg::*;
#(
    parameter int DEB_CNT = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic raw_i,
    output logic level_o,
    output logic riseReq_o
);

    localparam int             CW       = cntWidth(DEB_CNT);
    localparam logic [CW-1:0]  DEB_LAST = CW'(DEB_CNT - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count disagreeing ticks; the tick that completes the run flips the
    // level and restarts the count for the opposite transition.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (tick_i) begin
            if (sync2_q != level_q) begin
                if (cnt_q == DEB_LAST) begin
                    level_d = ~level_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    // Accepted level and run counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // The rise request is combinational so the parent can register its
    // pulse on the same edge that raises level_o.
    assign riseReq_o = level_d & ~level_q;
    assign level_o   = level_q;

endmodule

// File: rtl/calc_input_ctrl.sv
// ---------------------------------------------------------------------------
// calc_input_ctrl
// Input front end of the calculator: scans a 4x4 active-low keypad one
// column per slot, debounces presses and releases, emits one flag pulse per
// accepted press with its key code, and debounces the S2 push-button.
// Key flag and button pulse are serialised so they never coincide.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   row       in   [3:0] raw keypad rows, active-low, asynchronous
//   s2_raw    in   raw push-button, active-high, asynchronous
//   col       out  [3:0] keypad column drive, active-low one-hot
//   flag      out  one-cycle pulse for an accepted key press
//   key_data  out  [3:0] code of the last accepted key
//   s2_out    out  debounced button level
//   valid_s2  out  one-cycle pulse on the debounced button rising edge
// ---------------------------------------------------------------------------
module calc_input_ctrl
    import calc_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEB_CNT  = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    input  logic       s2_raw,
    output logic [3:0] col,
    output logic       flag,
    output logic [3:0] key_data,
    output logic       s2_out,
    output logic       valid_s2
);

    localparam int             DW       = cntWidth(SCAN_DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);
    localparam int             CW       = cntWidth(DEB_CNT);
    localparam logic [CW-1:0]  DEB_LAST = CW'(DEB_CNT - 1);

    logic [3:0]    rowSync1_q;
    logic [3:0]    rowSync2_q;
    logic [DW-1:0] divCnt_q;
    logic          tick;

    keyState_e     state_q;
    keyState_e     state_d;
    logic [1:0]    colIdx_q;
    logic [1:0]    colIdx_d;
    logic [1:0]    rowIdx_q;
    logic [1:0]    rowIdx_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [3:0]    keyData_q;
    logic [3:0]    keyData_d;
    logic          flag_q;
    logic          flag_d;
    logic          rowBit;

    logic          s2RiseReq;
    logic          validS2_q;
    logic          validS2_d;
    logic          pending_q;
    logic          pending_d;

    // Row synchroniser; idle keypad rows read high, so reset to all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rowSync1_q <= 4'hF;
            rowSync2_q <= 4'hF;
        end else begin
            rowSync1_q <= row;
            rowSync2_q <= rowSync1_q;
        end
    end

    // Free-running slot divider; the tick is the last count of each slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divCnt_q <= '0;
        end else if (tick) begin
            divCnt_q <= '0;
        end else begin
            divCnt_q <= divCnt_q + 1'b1;
        end
    end

    assign tick = (divCnt_q == DIV_LAST);

    // Row bit of the key being tracked, valid outside SCAN.
    assign rowBit = rowSync2_q[rowIdx_q];

    // Keypad FSM next state. Everything advances only on slot ticks. In SCAN
    // the rows are sampled for the column currently driven, before the
    // column moves on; once a key is seen the column stays frozen until the
    // FSM is back in SCAN, so only that column's rows are observed.
    always_comb begin
        state_d   = state_q;
        colIdx_d  = colIdx_q;
        rowIdx_d  = rowIdx_q;
        cnt_d     = cnt_q;
        keyData_d = keyData_q;
        flag_d    = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (rowSync2_q != 4'hF) begin
                        rowIdx_d = lowestLowRow(rowSync2_q);
                        cnt_d    = '0;
                        state_d  = DEBOUNCE;
                    end else begin
                        colIdx_d = colIdx_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (!rowBit) begin
                        if (cnt_q == DEB_LAST) begin
                            flag_d    = 1'b1;
                            keyData_d = keyCode(rowIdx_q, colIdx_q);
                            cnt_d     = '0;
                            state_d   = HOLD;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = SCAN;
                    end
                end
                HOLD: begin
                    if (rowBit) begin
                        cnt_d   = '0;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (rowBit) begin
                        if (cnt_q == DEB_LAST) begin
                            cnt_d   = '0;
                            state_d = SCAN;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = SCAN;
                end
            endcase
        end
    end

    // Keypad FSM registers and key outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SCAN;
            colIdx_q  <= 2'd0;
            rowIdx_q  <= 2'd0;
            cnt_q     <= '0;
            keyData_q <= 4'd0;
            flag_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            colIdx_q  <= colIdx_d;
            rowIdx_q  <= rowIdx_d;
            cnt_q     <= cnt_d;
            keyData_q <= keyData_d;
            flag_q    <= flag_d;
        end
    end

    // Push-button debouncer, stepped by the same slot tick as the keypad.
    calc_debounce #(
        .DEB_CNT (DEB_CNT)
    ) u_s2Debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_i    (tick),
        .raw_i     (s2_raw),
        .level_o   (s2_out),
        .riseReq_o (s2RiseReq)
    );

    // Button pulse arbitration: the key flag wins a collision and the button
    // pulse is parked for exactly one cycle. Both requests only arise on
    // ticks, at least one slot apart, so the parked pulse never meets a new
    // one and a single pending bit suffices.
    always_comb begin
        validS2_d = pending_q | (s2RiseReq & ~flag_d);
        pending_d = s2RiseReq & flag_d;
    end

    // Button pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validS2_q <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            validS2_q <= validS2_d;
            pending_q <= pending_d;
        end
    end

    assign col      = colDrive(colIdx_q);
    assign flag     = flag_q;
    assign key_data = keyData_q;
    assign valid_s2 = validS2_q;

endmodule

// File: tb/tb_calc_input_ctrl.sv
// ---------------------------------------------------------------------------
// tb_calc_input_ctrl
// Self-checking bench for calc_input_ctrl with SCAN_DIV=4, DEB_CNT=3.
// A behavioural keypad turns pressed keys into row levels from the DUT's
// column drive. Expected key codes and button pulses are queued when the
// stimulus is applied and compared as the DUT emits flag / valid_s2.
// ---------------------------------------------------------------------------
module tb_calc_input_ctrl;

    localparam int SCAN_DIV = 4;
    localparam int DEB_CNT  = 3;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [3:0] row;
    logic       s2_raw = 1'b0;
    logic [3:0] col;
    logic       flag;
    logic [3:0] key_data;
    logic       s2_out;
    logic       valid_s2;

    logic [15:0] keyDown = '0;

    int compareCount  = 0;
    int mismatchCount = 0;
    int cycleCount    = 0;

    logic [3:0] flagQ[$];
    int         validQ[$];

    // Key code expected at [row][col].
    logic [3:0] keyTable [4][4] = '{'{4'd1,  4'd2, 4'd3,  4'd10},
                                    '{4'd4,  4'd5, 4'd6,  4'd11},
                                    '{4'd7,  4'd8, 4'd9,  4'd12},
                                    '{4'd14, 4'd0, 4'd15, 4'd13}};

    int keyR[7] = '{0, 0, 3, 3, 3, 3, 2};
    int keyC[7] = '{0, 3, 0, 1, 2, 3, 2};

    calc_input_ctrl #(
        .SCAN_DIV (SCAN_DIV),
        .DEB_CNT  (DEB_CNT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row      (row),
        .s2_raw   (s2_raw),
        .col      (col),
        .flag     (flag),
        .key_data (key_data),
        .s2_out   (s2_out),
        .valid_s2 (valid_s2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Keypad: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keyDown[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Scoreboard: every flag / valid_s2 pulse must match a queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (flag) begin
                checkOutput("flagExpected", 32'(flagQ.size() != 0), 32'd1);
                if (flagQ.size() != 0) checkOutput("keyData", 32'(key_data), 32'(flagQ.pop_front()));
            end
            if (valid_s2) begin
                checkOutput("validExpected", 32'(validQ.size() != 0), 32'd1);
                if (validQ.size() != 0) void'(validQ.pop_front());
            end
            if (flag || valid_s2) checkOutput("noOverlap", 32'(flag & valid_s2), 32'd0);
        end
    end

    task automatic waitCol(input logic [3:0] target, input bit equal);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((col == target) == equal) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("colWait", 32'(ok), 32'd1);
    endtask

    // Waits for flag (whichValid=0) or valid_s2 (whichValid=1); returns the
    // cycle count at which it was seen.
    task automatic waitForPulse(input bit whichValid, input int maxCycles, output int seenCycle);
        bit seen = 1'b0;
        seenCycle = -1;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if ((whichValid ? valid_s2 : flag) === 1'b1) begin
                seen = 1'b1;
                seenCycle = cycleCount;
                break;
            end
        end
        checkOutput(whichValid ? "validSeen" : "flagSeen", 32'(seen), 32'd1);
    endtask

    task automatic applyStimulus(input logic [15:0] keys, input int holdCycles,
                                 input bit expectFlag, input logic [3:0] expCode);
        if (expectFlag) flagQ.push_back(expCode);
        keyDown = keys;
        repeat (holdCycles) @(negedge clk);
        keyDown = '0;
        repeat (40) @(negedge clk);
    endtask

    initial begin
        int fc;
        int vc;
        int relCycle;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("rstCol", 32'(col), 32'(4'b1110));
        checkOutput("rstFlag", 32'(flag), 32'd0);
        checkOutput("rstKeyData", 32'(key_data), 32'd0);
        checkOutput("rstS2Out", 32'(s2_out), 32'd0);
        checkOutput("rstValidS2", 32'(valid_s2), 32'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // Row 2 / column 1 held for ten slots: a single flag with code 8.
        applyStimulus(16'(1) << (2*4+1), 10*SCAN_DIV, 1'b1, keyTable[2][1]);
        checkOutput("holdSingleFlag", 32'(flagQ.size()), 32'd0);

        // Key map spot checks across the operator and symbol keys.
        for (int k = 0; k < 7; k++) begin
            applyStimulus(16'(1) << (keyR[k]*4 + keyC[k]), 12*SCAN_DIV, 1'b1, keyTable[keyR[k]][keyC[k]]);
        end

        // Two keys in column 0: the lower row index (row 1 -> 4) wins.
        applyStimulus((16'(1) << (1*4+0)) | (16'(1) << (3*4+0)), 12*SCAN_DIV, 1'b1, keyTable[1][0]);

        // Bounce: row 0 low for two ticks only; no flag, scanning resumes.
        waitCol(4'b1110, 1'b0);
        waitCol(4'b1110, 1'b1);
        keyDown[0] = 1'b1;
        repeat (2*SCAN_DIV) @(negedge clk);
        keyDown[0] = 1'b0;
        repeat (2*SCAN_DIV) @(negedge clk);
        checkOutput("bounceColResume", 32'(col), 32'(4'b1101));
        repeat (20) @(negedge clk);

        // Button: press long enough to debounce, then release.
        validQ.push_back(1);
        s2_raw = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("s2EarlyLow", 32'(s2_out), 32'd0);
        repeat (14) @(negedge clk);
        checkOutput("s2High", 32'(s2_out), 32'd1);
        s2_raw = 1'b0;
        repeat (24) @(negedge clk);
        checkOutput("s2Low", 32'(s2_out), 32'd0);
        checkOutput("s2PulseCount", 32'(validQ.size()), 32'd0);

        // Key r1/c3 and button accepted on the same tick: flag first, then
        // valid_s2 one cycle later.
        waitCol(4'b0111, 1'b0);
        keyDown = 16'(1) << (1*4+3);
        waitCol(4'b0111, 1'b1);
        flagQ.push_back(keyTable[1][3]);
        validQ.push_back(1);
        repeat (SCAN_DIV) @(negedge clk);
        s2_raw = 1'b1;
        waitForPulse(1'b0, 100, fc);
        waitForPulse(1'b1, 10, vc);
        checkOutput("validAfterFlag", 32'(vc - fc), 32'd1);
        repeat (20) @(negedge clk);
        keyDown = '0;
        s2_raw  = 1'b0;
        repeat (60) @(negedge clk);

        // Reset while key 5 is held in HOLD; it must be re-debounced.
        waitCol(4'b1101, 1'b0);
        flagQ.push_back(keyTable[1][1]);
        keyDown = 16'(1) << (1*4+1);
        waitForPulse(1'b0, 100, fc);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstCol", 32'(col), 32'(4'b1110));
        checkOutput("midRstFlag", 32'(flag), 32'd0);
        checkOutput("midRstKeyData", 32'(key_data), 32'd0);
        repeat (3) @(negedge clk);
        flagQ.push_back(keyTable[1][1]);
        rst_n = 1'b1;
        relCycle = cycleCount;
        waitForPulse(1'b0, 100, fc);
        checkOutput("reDebounceLatency", 32'(fc - relCycle), 32'd20);
        repeat (10) @(negedge clk);
        keyDown = '0;
        repeat (60) @(negedge clk);

        checkOutput("flagQueueEmpty", 32'(flagQ.size()), 32'd0);
        checkOutput("validQueueEmpty", 32'(validQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no completion, required finish before time limit");
        $fatal(1);
    end

endmodule

// File: doc/calc_input_ctrl.md
CALC_INPUT_CTRL -- requirements
Module: calc_input_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per column slot (1 ms at 50 MHz).
REQ-002 SHALL have parameter DEB_CNT, default 20, consecutive stable slots required to accept a press or release.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port row  input  4  raw keypad rows, active-low, asynchronous.
REQ-006 SHALL have port s2_raw  input  1  raw push-button, active-high, asynchronous.
REQ-007 SHALL have port col  output  4  keypad column drive, active-low one-hot.
REQ-008 SHALL have port flag  output  1  one-cycle pulse, accepted key press.
REQ-009 SHALL have port key_data  output  4  key code, valid while flag=1, held until the next event.
REQ-010 SHALL have port s2_out  output  1  debounced button level.
REQ-011 SHALL have port valid_s2  output  1  one-cycle pulse on debounced button rising edge.

Function
REQ-012 SHALL pass row and s2_raw each through a 2-FF synchronizer before any use.
REQ-013 SHALL generate a slot tick every SCAN_DIV clocks from a free-running counter wrapping at SCAN_DIV-1.
REQ-014 SHALL rotate col 1110->1101->1011->0111->1110 on each tick, in SCAN state only.
REQ-015 SHALL sample the synchronized row on each tick, before col advances.
REQ-016 SHALL implement FSM states SCAN, DEBOUNCE, HOLD, RELEASE.
REQ-017 SCAN: on a sampled row != 1111, SHALL latch col index and lowest-index low row bit, freeze col, and go to DEBOUNCE.
REQ-018 DEBOUNCE: SHALL count ticks with the latched row bit low; after DEB_CNT ticks, pulse flag with the mapped code and go to HOLD; latched bit high on any tick -> back to SCAN, no flag.
REQ-019 HOLD: SHALL wait for the latched row bit high on a tick, then go to RELEASE; no further flag while held, so there is no auto-repeat.
REQ-020 RELEASE: SHALL count DEB_CNT consecutive high ticks, then go to SCAN and resume rotation from the frozen column; a low tick returns to HOLD.
REQ-021 Key map (row r, col c) SHALL be: r0: 1,2,3,10; r1: 4,5,6,11; r2: 7,8,9,12; r3: 14,0,15,13.
REQ-022 s2_out SHALL change only after the synchronized s2_raw differs from s2_out for DEB_CNT consecutive ticks; any agreeing tick clears the count.
REQ-023 valid_s2 SHALL pulse one cycle when s2_out goes 0->1; no pulse on 1->0.
REQ-024 flag and valid_s2 SHALL never be high in the same cycle; on coincidence, flag is issued first and valid_s2 one cycle later from a one-entry pending register.
REQ-025 A second valid_s2 request while one is pending is impossible by construction (debounce >= 1 slot) and SHALL NOT be queued.
REQ-026 Multiple simultaneous keys SHALL be resolved by the lowest row index in the current column; other columns are ignored until return to SCAN.

Reset
REQ-027 On rst_n low, SHALL asynchronously set: col=1110, flag=0, key_data=0, s2_out=0, valid_s2=0, FSM=SCAN, all counters, synchronizers and pending register to 0 (row synchronizers to 1111).
REQ-028 Reset mid-debounce or mid-hold SHALL discard the event with no flag after release of reset; a key still held then SHALL be re-debounced from SCAN.

Structure
REQ-029 Shared package calc_pkg SHALL hold key-code constants (KEY_ADD=10, KEY_SUB=11, KEY_MUL=12, KEY_DIV=13, KEY_STAR=14, KEY_HASH=15) and the FSM state enum.
REQ-030 A sub-module calc_debounce (sync + tick-based counter + rising-edge pulse) SHALL be used for s2_raw.

Verification (SCAN_DIV=4, DEB_CNT=3)
REQ-031 Hold row2 low while col=1101 for 10 ticks -> exactly one flag, key_data=8.
REQ-032 Bounce row0 low for 2 ticks, then high -> no flag, FSM back in SCAN.
REQ-033 Hold s2_raw=1 for 5 ticks -> s2_out=1 after 3 ticks plus sync latency, one valid_s2 pulse; release -> s2_out=0, no pulse.
REQ-034 Key press and s2 accepted in the same cycle -> flag in cycle N (key_data=11 for r1/c3), valid_s2 in cycle N+1.
REQ-035 Assert rst_n low during HOLD with key 5 held, then release -> col=1110, no flag until re-debounce completes, then one flag with key_data=5.
